amm_rd_master: RTL
==================

Name: amm_rd_master

Overview:
- Avalon-MM pipelined read initiator. It is the RTL counterpart to the bench-side read responder.
- On a run pulse, it issues `word_cnt_i` single-word reads from consecutive word addresses starting at `base_addr_i`.
- Returned data is buffered in an internal FIFO and presented on a valid/ready stream.
- Sits in front of the byte-increment datapath, supplying source words fetched from memory.

Parameters:
- DATA_WIDTH, 64, width of readdata and stream data.
- ADDR_WIDTH, 10, word address width.
- CNT_WIDTH, 11, width of word_cnt_i (max transfer 2^CNT_WIDTH-1 words).
- MAX_OUTSTANDING, 4, FIFO depth and credit limit; power of two, ≥2.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  synchronous reset, active-high.
- run_i  input  1  start pulse; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first word address; captured with run_i.
- word_cnt_i  input  CNT_WIDTH  number of words; captured with run_i.
- busy_o  output  1  high from the cycle after an accepted run_i until done_o.
- done_o  output  1  one-cycle pulse after the last word leaves the stream.
- amm_address_o  output  ADDR_WIDTH  Avalon read address.
- amm_read_o  output  1  Avalon read request.
- amm_readdata_i  input  DATA_WIDTH  Avalon read data.
- amm_readdatavalid_i  input  1  Avalon read data valid.
- amm_waitrequest_i  input  1  Avalon stall.
- data_o  output  DATA_WIDTH  stream data (FIFO head).
- data_valid_o  output  1  stream valid.
- data_ready_i  input  1  stream ready.

Behaviour:
- Reset: all outputs 0 (`busy_o`, `done_o`, `amm_read_o`, `amm_address_o`, `data_valid_o`, `data_o`). FIFO emptied, counters cleared, state IDLE.
- Reset is asserted mid-transfer:
  - Abort immediately; next cycle is IDLE with outputs at reset values.
  - Outstanding responses are discarded.
  - `amm_readdatavalid_i` is ignored in IDLE.
- States:
  - IDLE: run_i=1 latches base/count.
    - count≠0: go to READ.
    - count=0: go to DONE (no bus activity).
  - READ: issue reads. When issued count = word_cnt, go to DRAIN.
  - DRAIN: wait until received count = word_cnt, the FIFO is empty, and the last beat has been accepted on the stream; then go to DONE.
  - DONE: `done_o`=1 for one cycle, `busy_o`=0, return to IDLE.
- Latency: run_i in cycle N gives busy_o=1 and, if a credit is available, amm_read_o=1 in cycle N+1.
- Request handshake:
  - A read is accepted in a cycle with amm_read_o=1 and amm_waitrequest_i=0.
  - While waitrequest=1, amm_read_o and amm_address_o hold stable.
  - amm_read_o never drops without acceptance.
- Address: base + issued count, modulo 2^ADDR_WIDTH; wraps 2^ADDR_WIDTH-1 → 0.
- Credits:
  - A new read may be presented only if outstanding + fifo_used < MAX_OUTSTANDING.
  - The FIFO therefore can never overflow, and `amm_readdatavalid_i` is always accepted (no backpressure on responses).
- Simultaneous events:
  - Acceptance, response and stream pop may all occur in the same cycle.
  - Counters update by the net change.
  - A credit freed by a pop in cycle N may be used in cycle N+1, not N.
- Stream:
  - Words emerge in request order.
  - `data_valid_o`=1 whenever the FIFO is non-empty; `data_o` = FIFO head.
  - A beat transfers when valid & ready.
  - data_o holds stable while valid & !ready.
- run_i while busy_o=1 is ignored, as are base_addr_i and word_cnt_i changes.
- Responses arriving beyond word_cnt (protocol violation) are undefined; the bench checks that the master never issues more than word_cnt reads.

Test Plan:
- Basic, no stalls:
  - Stimulus: base=0x010, cnt=8, waitrequest=0, read latency 2, ready=1.
  - Required: addresses 0x010..0x017 issued back-to-back, data out in order, done_o pulses once, exactly 8 reads.
- Waitrequest stall:
  - Stimulus: waitrequest=1 for 3 cycles on the 2nd request, cnt=4.
  - Required: address 0x011 and read held for 4 cycles, no duplicated or skipped address.
- Backpressure and credits:
  - Stimulus: ready=0, cnt=10, MAX_OUTSTANDING=4.
  - Required: exactly 4 reads issued, then amm_read_o=0 until ready=1; all 10 words delivered in order.
- Wrap and zero length:
  - Stimulus: base=0x3FE, cnt=4.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - Stimulus: cnt=0.
  - Required: done_o pulses 2 cycles after run_i, no amm_read_o.
- Reset mid-transfer and ignored run:
  - Stimulus: srst_i asserted with 3 reads outstanding.
  - Required: next cycle all outputs 0; late readdatavalid is not emitted; a fresh run then works.
  - Stimulus: run_i during busy.
  - Required: no effect.

Source files
------------

// File: rtl/amm_rd_master.sv
// Avalon-MM pipelined read initiator: fetches word_cnt_i consecutive words from
// base_addr_i and streams the responses out of a credit-limited FIFO.
module amm_rd_master #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int CNT_WIDTH       = 11,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  run_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  word_cnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] amm_address_o,
    output logic                  amm_read_o,
    input  logic [DATA_WIDTH-1:0] amm_readdata_i,
    input  logic                  amm_readdatavalid_i,
    input  logic                  amm_waitrequest_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i
);

    localparam int PW = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  issued_q;
    logic [CNT_WIDTH-1:0]  rcvd_q;
    logic [PW:0]           outst_q;
    logic [PW:0]           used_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [MAX_OUTSTANDING];

    logic                  accept;
    logic                  rsp;
    logic                  pop;
    logic [CNT_WIDTH-1:0]  issued_nxt;
    logic [PW:0]           outst_nxt;
    logic [PW:0]           used_nxt;
    logic                  credit_ok;

    assign data_valid_o = (used_q != '0);
    assign data_o       = data_valid_o ? mem[rd_ptr] : '0;

    // Credits are judged on post-edge counts, so a pop frees its slot one cycle later.
    always_comb begin
        accept     = amm_read_o & ~amm_waitrequest_i;
        rsp        = amm_readdatavalid_i & ((state == READ) || (state == DRAIN));
        pop        = data_valid_o & data_ready_i;
        issued_nxt = issued_q + CNT_WIDTH'(accept);
        outst_nxt  = outst_q + (PW+1)'(accept) - (PW+1)'(rsp);
        used_nxt   = used_q + (PW+1)'(rsp) - (PW+1)'(pop);
        credit_ok  = ({1'b0, outst_nxt} + {1'b0, used_nxt}) < (PW+2)'(MAX_OUTSTANDING);
    end

    always_ff @(posedge clk_i) begin
        if (rsp) begin
            mem[wr_ptr] <= amm_readdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state         <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            issued_q      <= '0;
            rcvd_q        <= '0;
            outst_q       <= '0;
            used_q        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            amm_read_o    <= 1'b0;
            amm_address_o <= '0;
        end else begin
            issued_q <= issued_nxt;
            rcvd_q   <= rcvd_q + CNT_WIDTH'(rsp);
            outst_q  <= outst_nxt;
            used_q   <= used_nxt;
            if (rsp) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            done_o <= 1'b0;

            case (state)
                IDLE: begin
                    amm_read_o <= 1'b0;
                    if (run_i) begin
                        base_q   <= base_addr_i;
                        cnt_q    <= word_cnt_i;
                        issued_q <= '0;
                        rcvd_q   <= '0;
                        busy_o   <= 1'b1;
                        if (word_cnt_i != '0) begin
                            state         <= READ;
                            amm_read_o    <= 1'b1;
                            amm_address_o <= base_addr_i;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (amm_read_o && amm_waitrequest_i) begin
                        amm_read_o <= 1'b1;
                    end else if (issued_nxt == cnt_q) begin
                        amm_read_o <= 1'b0;
                        state      <= DRAIN;
                    end else if (credit_ok) begin
                        amm_read_o    <= 1'b1;
                        amm_address_o <= base_q + ADDR_WIDTH'(issued_nxt);
                    end else begin
                        amm_read_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    if ((rcvd_q == cnt_q) && (used_q == '0)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
